if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch front end that replaces the fixed single-entry PC/IF-ID pairing with a fetch PC register and a DEPTH-entry instruction queue between the asynchronous-read instruction memory and the decode stage. Fetch continues while decode stalls (load-use) until the queue fills. A single-cycle redirect (branch, jump, jump register) flushes all queued wrong-path instructions and restarts fetch at the target. Decode consumes entries via a valid/ready handshake.

## Interface
- ADDR_W, 32, PC and instruction-memory address width
- DATA_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 0, fetch PC after reset
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (state cleared while rst==0)
- imem_addr  output  ADDR_W  fetch address; equals fetch PC register
- imem_data  input  DATA_W  instruction at imem_addr, same cycle (combinational read)
- fetch_en  input  1  1 = fetch allowed this cycle; 0 = hold fetch PC, no enqueue
- redirect  input  1  flush queue, restart fetch at redirect_pc
- redirect_pc  input  ADDR_W  target; bits [1:0] ignored, treated as 00
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode accepts head this cycle
- out_inst  output  DATA_W  head instruction; 0 when out_valid==0
- out_pc4  output  ADDR_W  head instruction address + 4; 0 when out_valid==0
- count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH x {inst, pc4}; read pointer, write pointer, count; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- enq = fetch_en & !redirect & (count<DEPTH | (count==DEPTH & out_ready)).
- deq = out_valid & out_ready & !redirect.
- On enq: write {imem_data, imem_addr+4} at write pointer; fetch PC <= fetch PC + 4 (modulo 2^ADDR_W, wraps silently).
- No enq: fetch PC holds.
- count next = count + enq - deq; simultaneous enq and deq leaves count unchanged, including when full.
- redirect (highest priority): pointers and count cleared, fetch PC <= {redirect_pc[ADDR_W-1:2],2'b00}, no enq, no deq; out_valid forced 0 combinationally in that cycle.
- out_valid = (count!=0) & !redirect (without bypass).
- Queue contents are not cleared by redirect; only pointers and count.

## Timing
- Reset values: fetch PC=RESET_PC, imem_addr=RESET_PC, count=0, pointers=0, out_valid=0, out_inst=0, out_pc4=0.
- Queue latency: instruction present on imem_data in cycle N is visible on out_* in cycle N+1 at earliest.
- Redirect in cycle N: imem_addr=target in N+1; first target instruction on out_* in N+2 (N+1 with bypass).
- Full (count==DEPTH) with out_ready=0: fetch PC and imem_addr hold, contents stable.
- Empty with fetch_en=0: out_valid stays 0, fetch PC holds.
- rst asserted mid-operation: all state returns to reset values immediately, regardless of clk; first fetch at RESET_PC on the first clk edge after rst deasserts.
- Combinational paths: out_ready->enq->fetch PC next; redirect->out_valid. Nothing from imem_data to out_* except under bypass.

## Configuration
- FETCH_BYPASS_EN defined: when count==0, fetch_en=1, and redirect=0, out_valid=1 with out_inst=imem_data and out_pc4=imem_addr+4 in the same cycle. If out_ready=1 the word is consumed without being written (count stays 0, fetch PC advances). If out_ready=0 it is enqueued normally.
- Not defined: out_* driven only from the queue head; 1-cycle minimum latency; no imem_data->out_inst path.

## Test plan
- Reset then fetch_en=1, out_ready=1, imem_data=addr-based pattern: out_pc4 sequence 4,8,12,... one per cycle from cycle 2 (cycle 1 with bypass); count stays <=1.
- out_ready=0 for 10 cycles from reset, DEPTH=4: count climbs 1..4 and saturates; imem_addr freezes at 16; releasing ready drains entries in order 0,4,8,12, then 16 follows with no gap.
- Full queue, out_ready=1 held: enq and deq every cycle, count stays 4, no instruction dropped or duplicated.
- redirect=1, redirect_pc=0x103 while count=3 and out_ready=1: out_valid=0 that cycle, count=0 next cycle, imem_addr=0x100, next delivered out_pc4=0x104.
- rst driven low mid-stream between clock edges: count, out_valid, out_* zero immediately; imem_addr=RESET_PC.
- Fetch PC at 0xFFFFFFFC, ADDR_W=32: next imem_addr=0x0; out_pc4 for that entry = 0x0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end.
// A fetch PC drives an asynchronous-read instruction memory. Fetched words are pushed into a
// DEPTH-entry queue, and decode pops them with a valid/ready handshake. Fetch keeps running
// while decode stalls, until the queue fills. A redirect flushes every queued wrong-path entry
// and restarts fetch at the target address.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, an empty queue forwards
// imem_data straight to the out_* ports in the same cycle.
module if_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_pc4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INST_BYTES = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc4_mem  [DEPTH];

    logic [ADDR_W-1:0] fetch_pc4;
    logic              empty;
    logic              full;
    logic              bypass;
    logic              enq;
    logic              deq;
    logic              wr_en;
    logic              rd_en;

    // Target alignment drops the low two bits, so they are intentionally unused.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign fetch_pc4 = fetch_pc_q + INST_BYTES;
    assign imem_addr = fetch_pc_q;
    assign count     = count_q;

    // Handshake decode: decide what is fetched, stored and consumed this cycle.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
`ifdef FETCH_BYPASS_EN
        bypass = empty & fetch_en & ~redirect;
`else
        bypass = 1'b0;
`endif
        out_valid = (~empty | bypass) & ~redirect;
        // When the queue is full, a same-cycle pop frees the slot that is being written.
        enq   = fetch_en & ~redirect & (~full | out_ready);
        deq   = out_valid & out_ready;
        // A bypassed word that is accepted at once never occupies a slot.
        wr_en = enq & ~(bypass & out_ready);
        rd_en = deq & ~bypass;
    end

    // Next-state for the fetch PC, the pointers and the occupancy; redirect wins over everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc4;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage. Entries are not reset, because count gates every read of them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[wr_ptr_q] <= imem_data;
            pc4_mem[wr_ptr_q]  <= fetch_pc4;
        end
    end

    // Head presentation: the outputs are zeroed whenever no valid entry is offered.
    always_comb begin
        out_inst = '0;
        out_pc4  = '0;
        if (out_valid) begin
`ifdef FETCH_BYPASS_EN
            if (bypass) begin
                out_inst = imem_data;
                out_pc4  = fetch_pc4;
            end else begin
                out_inst = inst_mem[rd_ptr_q];
                out_pc4  = pc4_mem[rd_ptr_q];
            end
`else
            out_inst = inst_mem[rd_ptr_q];
            out_pc4  = pc4_mem[rd_ptr_q];
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue.
// It runs a directed vector table, hand sequences for async reset and address wrap, and a
// randomized run that is checked against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc4;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;

    typedef struct {
        logic        fe;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc4;
        int          ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tv[15];

    if_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc4     (out_pc4),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
    endtask

    function automatic bit model_bypass();
`ifdef FETCH_BYPASS_EN
        return (mq.size() == 0) && fetch_en && !redirect;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model(input string tag);
        bit          byp;
        bit          ev;
        logic [31:0] ei;
        logic [31:0] ep;
        byp = model_bypass();
        ev  = !redirect && (mq.size() != 0 || byp);
        ei  = '0;
        ep  = '0;
        if (ev) begin
            if (byp) begin
                ei = mem_word(mpc);
                ep = mpc + 32'd4;
            end else begin
                ei = mq[0].inst;
                ep = mq[0].pc4;
            end
        end
        chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".inst"},  64'(out_inst),  64'(ei));
        chk({tag, ".pc4"},   64'(out_pc4),   64'(ep));
        chk({tag, ".count"}, 64'(count),     64'(mq.size()));
        chk({tag, ".addr"},  64'(imem_addr), 64'(mpc));
    endtask

    // Advance the model across the coming clock edge, using the inputs as currently driven.
    task automatic model_step();
        bit byp;
        bit ev;
        bit full;
        byp = model_bypass();
        ev  = !redirect && (mq.size() != 0 || byp);
        if (redirect) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else if (byp && out_ready) begin
            mpc = mpc + 32'd4;
        end else begin
            full = (mq.size() == DEPTH);
            if (ev && out_ready) void'(mq.pop_front());
            if (fetch_en && (!full || out_ready)) begin
                mq.push_back({mem_word(mpc), mpc + 32'd4});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic fe, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           fe    rd    rpc          rdy   ev    epc4       cnt eaddr
        tv[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   0, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1, 32'h4};
        tv[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   2, 32'h8};
        tv[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   3, 32'hC};
        tv[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   4, 32'h10};
        tv[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   4, 32'h10};
        tv[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   4, 32'h10};
        tv[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   4, 32'h14};
        tv[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   4, 32'h18};
        tv[9]  = '{1'b1, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0,   3, 32'h18};
        tv[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 32'h100};
        tv[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1, 32'h104};
        tv[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1, 32'h108};
        tv[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1, 32'h108};
        tv[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 32'h108};

        rst         = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        model_reset();
        #12;
        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.inst",  64'(out_inst),  64'd0);
        chk("reset.pc4",   64'(out_pc4),   64'd0);
        chk("reset.count", 64'(count),     64'd0);
        chk("reset.addr",  64'(imem_addr), 64'(RESET_PC));
        @(negedge clk);
        rst = 1'b1;

`ifndef FETCH_BYPASS_EN
        // Fill while stalled, drain in order, then redirect with count==3.
        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tv[i].fe, tv[i].rd, tv[i].rpc, tv[i].rdy);
            chk({t, ".valid"}, 64'(out_valid), 64'(tv[i].ev));
            chk({t, ".pc4"},   64'(out_pc4),   64'(tv[i].epc4));
            chk({t, ".inst"},  64'(out_inst),
                64'(tv[i].ev ? mem_word(tv[i].epc4 - 32'd4) : 32'h0));
            chk({t, ".count"}, 64'(count),     64'(tv[i].ecnt));
            chk({t, ".addr"},  64'(imem_addr), 64'(tv[i].eaddr));
            model_step();
        end
`endif

        // Async reset asserted between clock edges while the queue holds entries.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            check_model($sformatf("fill%0d", i));
            model_step();
        end
        #2;
        rst      = 1'b0;
        fetch_en = 1'b0;
        #1;
        chk("arst.valid", 64'(out_valid), 64'd0);
        chk("arst.inst",  64'(out_inst),  64'd0);
        chk("arst.pc4",   64'(out_pc4),   64'd0);
        chk("arst.count", 64'(count),     64'd0);
        chk("arst.addr",  64'(imem_addr), 64'(RESET_PC));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_model("post_arst0");
        model_step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_model("post_arst1");
        model_step();

        // Fetch PC wrap from the top of the address space.
        do_reset();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        check_model("wrap0");
        model_step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check_model("wrap1");
        model_step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap.addr",  64'(imem_addr), 64'd0);
        chk("wrap.valid", 64'(out_valid), 64'd1);
        chk("wrap.pc4",   64'(out_pc4),   64'd0);
        chk("wrap.inst",  64'(out_inst),  64'(mem_word(32'hFFFF_FFFC)));
        model_step();

        // Randomized traffic against the reference model.
        do_reset();
        begin
            int rdy_pct;
            rdy_pct = 70;
            for (int c = 0; c < 3000; c++) begin
                logic        fe;
                logic        rd;
                logic [31:0] rpc;
                logic        rdy;
                if (c % 64 == 0) rdy_pct = $urandom_range(10, 100);
                fe  = ($urandom_range(0, 9) < 8);
                rd  = ($urandom_range(0, 31) == 0);
                rpc = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h0) |
                      32'($urandom_range(0, 4095));
                rdy = ($urandom_range(1, 100) <= rdy_pct);
                drive(fe, rd, rpc, rdy);
                check_model($sformatf("rnd%0d", c));
                model_step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
